// File: rtl/snake_controller.sv
// rtl/snake_controller.sv - snake game sequencer: direction latch, step prescaler, segment shift, IDLE/RUN/PAUSE/OVER FSM
module snake_controller #(
   parameter int STEP_DIV = 4,
   parameter int WRAP     = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] switch,
   input  logic       start,
   input  logic       pause,
   output logic [5:0] first,
   output logic [5:0] second,
   output logic [5:0] third,
   output logic [5:0] fourth,
   output logic [1:0] direction,
   output logic [1:0] state,
   output logic       step,
   output logic [7:0] moves
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_OVER  = 2'b11
   } state_e;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;
   localparam logic [7:0] TERM      = 8'(STEP_DIV - 1);

   localparam logic [5:0] HOME0 = 6'o33;
   localparam logic [5:0] HOME1 = 6'o32;
   localparam logic [5:0] HOME2 = 6'o31;
   localparam logic [5:0] HOME3 = 6'o30;

   state_e     state_q, state_d;
   logic [5:0] first_q, first_d, second_q, second_d;
   logic [5:0] third_q, third_d, fourth_q, fourth_d;
   logic [1:0] dir_q, dir_d, pend_q, pend_d;
   logic [7:0] presc_q, presc_d, moves_q, moves_d;
   logic       step_q, step_d;

   logic       req_valid;
   logic [1:0] req_dir;
   logic [2:0] head_x, head_y, new_x, new_y;
   logic       leave;

   always_comb begin
      req_valid = 1'b1;
      req_dir   = DIR_RIGHT;
      if (switch[3])      req_dir = DIR_UP;
      else if (switch[2]) req_dir = DIR_DOWN;
      else if (switch[1]) req_dir = DIR_LEFT;
      else if (switch[0]) req_dir = DIR_RIGHT;
      else                req_valid = 1'b0;
   end

   // 3-bit arithmetic wraps for free; leave flags the move that crosses an edge
   always_comb begin
      head_x = first_q[2:0];
      head_y = first_q[5:3];
      new_x  = head_x;
      new_y  = head_y;
      leave  = 1'b0;
      case (pend_q)
         DIR_UP:   begin new_y = head_y - 3'd1; leave = (head_y == 3'd0); end
         DIR_DOWN: begin new_y = head_y + 3'd1; leave = (head_y == 3'd7); end
         DIR_LEFT: begin new_x = head_x - 3'd1; leave = (head_x == 3'd0); end
         default:  begin new_x = head_x + 3'd1; leave = (head_x == 3'd7); end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      first_d  = first_q;
      second_d = second_q;
      third_d  = third_q;
      fourth_d = fourth_q;
      dir_d    = dir_q;
      pend_d   = pend_q;
      presc_d  = presc_q;
      moves_d  = moves_q;
      step_d   = 1'b0;

      // reversal is judged against the applied direction, not the pending one
      if ((state_q == S_IDLE || state_q == S_RUN) && req_valid &&
          ((req_dir ^ 2'b01) != dir_q))
         pend_d = req_dir;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               presc_d = 8'd0;
            end
         end
         S_RUN: begin
            if (pause) begin
               state_d = S_PAUSE;
            end else if (presc_q == TERM) begin
               presc_d = 8'd0;
               if (leave && (WRAP == 0)) begin
                  state_d = S_OVER;
               end else begin
                  fourth_d = third_q;
                  third_d  = second_q;
                  second_d = first_q;
                  first_d  = {new_y, new_x};
                  dir_d    = pend_q;
                  if (moves_q != 8'hFF) moves_d = moves_q + 8'd1;
                  step_d   = 1'b1;
               end
            end else begin
               presc_d = presc_q + 8'd1;
            end
         end
         S_PAUSE: begin
            if (start) state_d = S_RUN;
         end
         S_OVER: begin
            if (start) begin
               first_d  = HOME0;
               second_d = HOME1;
               third_d  = HOME2;
               fourth_d = HOME3;
               dir_d    = DIR_RIGHT;
               moves_d  = 8'd0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         first_q  <= HOME0;
         second_q <= HOME1;
         third_q  <= HOME2;
         fourth_q <= HOME3;
         dir_q    <= DIR_RIGHT;
         pend_q   <= DIR_RIGHT;
         presc_q  <= 8'd0;
         moves_q  <= 8'd0;
         step_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         first_q  <= first_d;
         second_q <= second_d;
         third_q  <= third_d;
         fourth_q <= fourth_d;
         dir_q    <= dir_d;
         pend_q   <= pend_d;
         presc_q  <= presc_d;
         moves_q  <= moves_d;
         step_q   <= step_d;
      end
   end

   assign first     = first_q;
   assign second    = second_q;
   assign third     = third_q;
   assign fourth    = fourth_q;
   assign direction = dir_q;
   assign state     = state_q;
   assign step      = step_q;
   assign moves     = moves_q;

endmodule

// File: tb/tb_snake_controller.sv
// tb/tb_snake_controller.sv - random plus directed bench for snake_controller against a coordinate-level model
module tb_snake_controller;

   localparam int N = 3;
   int DIVS[N]  = '{4, 4, 1};
   int WRAPS[N] = '{1, 0, 1};
   int DX[4]    = '{0, 0, -1, 1};
   int DY[4]    = '{-1, 1, 0, 0};

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] switch = 4'b0000;

   logic [5:0] first_w[N], second_w[N], third_w[N], fourth_w[N];
   logic [1:0] dir_w[N], state_w[N];
   logic       step_w[N];
   logic [7:0] moves_w[N];

   int n_checks = 0;
   int n_err = 0;

   int m_st[N], m_dir[N], m_pend[N], m_pre[N], m_mv[N];
   int m_x[N][4], m_y[N][4];
   bit m_stp[N];
   bit m_valid = 1'b0;

   always #5 clk = ~clk;

   snake_controller #(.STEP_DIV(4), .WRAP(1)) dut_a (
      .clock(clk), .reset(reset), .switch(switch), .start(start), .pause(pause),
      .first(first_w[0]), .second(second_w[0]), .third(third_w[0]), .fourth(fourth_w[0]),
      .direction(dir_w[0]), .state(state_w[0]), .step(step_w[0]), .moves(moves_w[0]));

   snake_controller #(.STEP_DIV(4), .WRAP(0)) dut_b (
      .clock(clk), .reset(reset), .switch(switch), .start(start), .pause(pause),
      .first(first_w[1]), .second(second_w[1]), .third(third_w[1]), .fourth(fourth_w[1]),
      .direction(dir_w[1]), .state(state_w[1]), .step(step_w[1]), .moves(moves_w[1]));

   snake_controller #(.STEP_DIV(1), .WRAP(1)) dut_c (
      .clock(clk), .reset(reset), .switch(switch), .start(start), .pause(pause),
      .first(first_w[2]), .second(second_w[2]), .third(third_w[2]), .fourth(fourth_w[2]),
      .direction(dir_w[2]), .state(state_w[2]), .step(step_w[2]), .moves(moves_w[2]));

   task automatic chk(input string nm, input int inst, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, inst, $time, act, exp);
      end
   endtask

   task automatic home(input int i);
      for (int s = 0; s < 4; s++) begin
         m_x[i][s] = 3 - s;
         m_y[i][s] = 3;
      end
   endtask

   // advance model i by one clock edge using the inputs that edge will sample
   task automatic mstep(input int i);
      int req, np, nx, ny;
      bit opp;
      m_stp[i] = 1'b0;
      if (reset == 1'b0) begin
         m_st[i] = 0; m_dir[i] = 3; m_pend[i] = 3; m_pre[i] = 0; m_mv[i] = 0;
         home(i);
         return;
      end
      req = switch[3] ? 0 : switch[2] ? 1 : switch[1] ? 2 : switch[0] ? 3 : -1;
      opp = (req >= 0) && (req / 2 == m_dir[i] / 2) && (req != m_dir[i]);
      np = m_pend[i];
      if ((m_st[i] == 0 || m_st[i] == 1) && req >= 0 && !opp) np = req;
      case (m_st[i])
         0: if (start) begin m_st[i] = 1; m_pre[i] = 0; end
         1: begin
            if (pause) m_st[i] = 2;
            else if (m_pre[i] == DIVS[i] - 1) begin
               m_pre[i] = 0;
               nx = m_x[i][0] + DX[m_pend[i]];
               ny = m_y[i][0] + DY[m_pend[i]];
               if (WRAPS[i] == 0 && (nx < 0 || nx > 7 || ny < 0 || ny > 7)) m_st[i] = 3;
               else begin
                  for (int s = 3; s > 0; s--) begin
                     m_x[i][s] = m_x[i][s-1];
                     m_y[i][s] = m_y[i][s-1];
                  end
                  m_x[i][0] = (nx + 8) % 8;
                  m_y[i][0] = (ny + 8) % 8;
                  m_dir[i] = m_pend[i];
                  if (m_mv[i] < 255) m_mv[i]++;
                  m_stp[i] = 1'b1;
               end
            end else m_pre[i]++;
         end
         2: if (start) m_st[i] = 1;
         3: if (start) begin home(i); m_dir[i] = 3; m_mv[i] = 0; m_st[i] = 0; end
         default: ;
      endcase
      m_pend[i] = np;
   endtask

   task automatic cmp_all();
      for (int i = 0; i < N; i++) begin
         chk("state", i, int'(state_w[i]), m_st[i]);
         chk("first", i, int'(first_w[i]), m_y[i][0] * 8 + m_x[i][0]);
         chk("second", i, int'(second_w[i]), m_y[i][1] * 8 + m_x[i][1]);
         chk("third", i, int'(third_w[i]), m_y[i][2] * 8 + m_x[i][2]);
         chk("fourth", i, int'(fourth_w[i]), m_y[i][3] * 8 + m_x[i][3]);
         chk("direction", i, int'(dir_w[i]), m_dir[i]);
         chk("step", i, int'(step_w[i]), int'(m_stp[i]));
         chk("moves", i, int'(moves_w[i]), m_mv[i]);
      end
   endtask

   // each tick compares on the falling edge, then lets one rising edge pass
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         if (m_valid) cmp_all();
         for (int i = 0; i < N; i++) mstep(i);
         m_valid = 1'b1;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic lit_reset(input int i);
      chk("lit_rst_state", i, int'(state_w[i]), 0);
      chk("lit_rst_first", i, int'(first_w[i]), 6'o33);
      chk("lit_rst_second", i, int'(second_w[i]), 6'o32);
      chk("lit_rst_third", i, int'(third_w[i]), 6'o31);
      chk("lit_rst_fourth", i, int'(fourth_w[i]), 6'o30);
      chk("lit_rst_dir", i, int'(dir_w[i]), 3);
      chk("lit_rst_moves", i, int'(moves_w[i]), 0);
      chk("lit_rst_step", i, int'(step_w[i]), 0);
   endtask

   initial begin
      tick(2);
      for (int i = 0; i < N; i++) lit_reset(i);
      reset = 1'b1;

      start = 1'b1; tick(1); start = 1'b0;
      tick(20);
      chk("lit_wrap_first", 0, int'(first_w[0]), 6'o30);
      chk("lit_wrap_moves", 0, int'(moves_w[0]), 5);
      chk("lit_wrap_step", 0, int'(step_w[0]), 1);
      chk("lit_over_state", 1, int'(state_w[1]), 3);
      chk("lit_over_first", 1, int'(first_w[1]), 6'o37);
      chk("lit_over_moves", 1, int'(moves_w[1]), 4);
      chk("lit_over_step", 1, int'(step_w[1]), 0);
      chk("lit_div1_first", 2, int'(first_w[2]), 6'o37);
      chk("lit_div1_moves", 2, int'(moves_w[2]), 20);

      switch = 4'b0010; tick(4);
      chk("lit_rev_first", 0, int'(first_w[0]), 6'o31);
      chk("lit_rev_dir", 0, int'(dir_w[0]), 3);
      switch = 4'b1000; tick(4);
      chk("lit_up_first", 0, int'(first_w[0]), 6'o21);
      chk("lit_up_dir", 0, int'(dir_w[0]), 0);
      chk("lit_up_moves", 0, int'(moves_w[0]), 7);
      switch = 4'b0100; tick(4);
      chk("lit_down_ign_first", 0, int'(first_w[0]), 6'o11);

      tick(3);
      pause = 1'b1; tick(1);
      chk("lit_pause_state", 0, int'(state_w[0]), 2);
      chk("lit_pause_step", 0, int'(step_w[0]), 0);
      tick(9);
      chk("lit_frozen_first", 0, int'(first_w[0]), 6'o11);
      chk("lit_frozen_moves", 0, int'(moves_w[0]), 8);
      pause = 1'b0; start = 1'b1; tick(1);
      chk("lit_resume_state", 0, int'(state_w[0]), 1);
      chk("lit_resume_step", 0, int'(step_w[0]), 0);
      chk("lit_restart_state", 1, int'(state_w[1]), 0);
      chk("lit_restart_first", 1, int'(first_w[1]), 6'o33);
      chk("lit_restart_moves", 1, int'(moves_w[1]), 0);
      start = 1'b0; tick(1);
      chk("lit_resume_step1", 0, int'(step_w[0]), 1);
      chk("lit_resume_first", 0, int'(first_w[0]), 6'o01);
      chk("lit_resume_moves", 0, int'(moves_w[0]), 9);
      switch = 4'b0000;

      tick(3);
      reset = 1'b0; tick(1);
      for (int i = 0; i < N; i++) lit_reset(i);
      reset = 1'b1; switch = 4'b1001; start = 1'b1; tick(1);
      start = 1'b0; tick(4);
      chk("lit_prio_first", 0, int'(first_w[0]), 6'o23);
      chk("lit_prio_dir", 0, int'(dir_w[0]), 0);
      chk("lit_prio_moves", 0, int'(moves_w[0]), 1);

      for (int n = 0; n < 3000; n++) begin
         reset  = ($urandom_range(0, 99) != 0);
         start  = ($urandom_range(0, 9) == 0);
         pause  = ($urandom_range(0, 11) == 0);
         switch = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         tick(1);
      end
      reset = 1'b1; start = 1'b0; pause = 1'b0; switch = 4'b0000;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
